load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 100001: number of 32-bit words backing the data memory; word indices at or above this are out of range.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  core presents a load/store request.
REQ-005 SHALL have port req_ready  output  1  unit accepts the request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port req_unsigned  input  1  loads: 1 zero-extend, 0 sign-extend.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  request rejected, no memory write done.
REQ-014 SHALL have port mem_addr  output  32  word-aligned byte address to data memory.
REQ-015 SHALL have port mem_wdata  output  32  full word written to data memory.
REQ-016 SHALL have port mem_we  output  1  data memory write enable, sampled on clk rising edge.
REQ-017 SHALL have port mem_rdata  input  32  combinational read data of mem_addr, same cycle.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-019 SHALL latch all req_* fields on the edge where req_valid and req_ready are both 1.
REQ-020 SHALL transition from IDLE on acceptance: error -> RESP; load -> READ; word store -> WRITE; byte/half store -> READ.
REQ-021 SHALL, in READ, drive mem_addr = {addr[31:2],2'b00} and capture mem_rdata at cycle end; load -> RESP, sub-word store -> WRITE.
REQ-022 SHALL, in WRITE, assert mem_we with mem_wdata = captured word with only the addressed lanes replaced (little-endian; byte lane addr[1:0], half lane addr[1]), or req_wdata for word stores; then go to RESP.
REQ-023 SHALL, in RESP, assert resp_valid for exactly one cycle, then return to IDLE; no response back-pressure.
REQ-024 SHALL produce latency accept->resp_valid of 2 cycles for loads and word stores, 3 for sub-word stores, 1 for errors.
REQ-025 SHALL flag resp_err for req_size 11 or word index addr[31:2] >= MEM_WORDS, with no READ/WRITE issued.
REQ-026 SHALL drive mem_addr = 0, mem_wdata = 0, mem_we = 0 outside READ/WRITE.
REQ-027 SHALL extend byte/half loads per req_unsigned into resp_rdata, registered and held until the next RESP.
REQ-028 SHALL ignore req_valid outside IDLE; a request held across RESP is accepted in the following IDLE cycle.

Reset
REQ-029 SHALL, when rst_n = 0 at a rising edge, force IDLE and clear resp_valid, resp_rdata, resp_err, latched request and captured word to 0.
REQ-030 SHALL gate mem_we with rst_n so a WRITE in progress during reset performs no memory write; the aborted request never gets a response.

Configuration
REQ-031 SHALL, with LSU_MISALIGN_TRAP_EN defined, treat halfword with addr[0]=1 or word with addr[1:0]!=0 as an error per REQ-025.
REQ-032 SHALL, without LSU_MISALIGN_TRAP_EN, force natural alignment instead (half clears addr[0], word clears addr[1:0]) and proceed normally.

Verification
REQ-033 SHALL cover: mem word 0x0 = 0x8899AABB, load byte addr 0x1 signed -> resp_rdata 0xFFFFFFAA at accept+2.
REQ-034 SHALL cover: same word, load half addr 0x2 unsigned -> 0x00008899.
REQ-035 SHALL cover: store byte 0x5A to addr 0x2 over 0x8899AABB -> one mem_we cycle, word 0x885AAABB, resp_valid at accept+3.
REQ-036 SHALL cover: word load addr 0x6 -> with macro resp_err=1, mem_we never high; without macro reads word 0x4.
REQ-037 SHALL cover: addr 0x00061A84 (index 100001) word store -> resp_err=1 at accept+1, memory unchanged.
REQ-038 SHALL cover: rst_n low during WRITE of a store to 0x8 -> word 0x8 unchanged, state IDLE, req_ready=1 next cycle.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: sequences byte/half/word loads and stores to a word-wide
// combinational-read data memory; sub-word stores use read-modify-write.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word -> error;
// when undefined, half/word addresses are forced to natural alignment).
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready/req_we/req_size/
// req_unsigned/req_addr/req_wdata (request); resp_valid/resp_rdata/resp_err
// (one-cycle response); mem_addr/mem_wdata/mem_we/mem_rdata (data memory).
module load_store_unit #(
   parameter int unsigned MEM_WORDS = 100001
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      state_q, state_d;
   logic        we_q, uns_q, err_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q, word_q, rdata_q;

   logic        acc;
   logic        err_new;
   logic [31:0] addr_al;
   logic [31:0] widx;
   logic [4:0]  sh_amt;
   logic [31:0] rd_sh;
   logic [31:0] ld_ext;
   logic [31:0] lane_mask;
   logic [31:0] merged;

   assign acc = req_valid & (state_q == IDLE);

   // Request decode: alignment handling and error detection at acceptance.
   always_comb begin
      addr_al = req_addr;
`ifndef LSU_MISALIGN_TRAP_EN
      if (req_size == 2'b01) addr_al[0] = 1'b0;
      if (req_size == 2'b10) addr_al[1:0] = 2'b00;
`endif
      widx    = {2'b00, req_addr[31:2]};
      err_new = (req_size == 2'b11) | (widx >= 32'(MEM_WORDS));
`ifdef LSU_MISALIGN_TRAP_EN
      if (req_size == 2'b01 && req_addr[0]) err_new = 1'b1;
      if (req_size == 2'b10 && req_addr[1:0] != 2'b00) err_new = 1'b1;
`endif
   end

   // Lane shift shared by load extraction and store merge; halves are
   // always half-aligned here, so addr[0] contributes zero for them.
   assign sh_amt = {addr_q[1:0], 3'b000};
   assign rd_sh  = mem_rdata >> sh_amt;

   always_comb begin
      ld_ext = mem_rdata;
      unique case (size_q)
         2'b00: ld_ext = uns_q ? {24'h0, rd_sh[7:0]}
                               : {{24{rd_sh[7]}}, rd_sh[7:0]};
         2'b01: ld_ext = uns_q ? {16'h0, rd_sh[15:0]}
                               : {{16{rd_sh[15]}}, rd_sh[15:0]};
         default: ld_ext = mem_rdata;
      endcase
   end

   always_comb begin
      lane_mask = 32'hFFFF_FFFF;
      if (size_q == 2'b00) lane_mask = 32'h0000_00FF << sh_amt;
      if (size_q == 2'b01) lane_mask = 32'h0000_FFFF << sh_amt;
      merged = (word_q & ~lane_mask) | ((wdata_q << sh_amt) & lane_mask);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (acc) begin
               if (err_new)                state_d = RESP;
               else if (!req_we)           state_d = READ;
               else if (req_size == 2'b10) state_d = WRITE;
               else                        state_d = READ;
            end
         end
         READ:    state_d = we_q ? WRITE : RESP;
         WRITE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         word_q  <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         if (acc) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            err_q   <= err_new;
            size_q  <= req_size;
            addr_q  <= addr_al;
            wdata_q <= req_wdata;
            if (err_new) rdata_q <= 32'h0;
         end
         if (state_q == READ) begin
            word_q <= mem_rdata;
            if (!we_q) rdata_q <= ld_ext;
         end
         if (state_q == WRITE) rdata_q <= 32'h0;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_err   = (state_q == RESP) & err_q;
   assign resp_rdata = rdata_q;

   // Reset gates the write strobe so an interrupted WRITE leaves memory intact.
   assign mem_we    = (state_q == WRITE) & rst_n;
   assign mem_addr  = (state_q == READ || state_q == WRITE)
                      ? {addr_q[31:2], 2'b00} : 32'h0;
   assign mem_wdata = (state_q != WRITE) ? 32'h0
                      : (size_q == 2'b10) ? wdata_q : merged;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a small behavioural memory.
// Works with or without LSU_MISALIGN_TRAP_EN defined.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:63];
   int          we_cnt;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .mem_rdata    (mem_rdata)
   );

   assign mem_rdata = (mem_addr[31:8] == 24'h0) ? mem[mem_addr[7:2]] : 32'h0;

   always @(posedge clk) begin
      if (mem_we) begin
         we_cnt = we_cnt + 1;
         if (mem_addr[31:8] == 24'h0) mem[mem_addr[7:2]] <= mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request, wait (bounded) for resp_valid, check latency,
   // response fields, write count, and the one-cycle pulse.
   task automatic run(input string tag, input logic we, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a,
                      input logic [31:0] wd, input int exp_lat,
                      input logic exp_err, input logic [31:0] exp_rd,
                      input int exp_we);
      int k;
      @(posedge clk); #1;
      chk({tag, ".ready"}, {31'h0, req_ready}, 32'd1);
      we_cnt       = 0;
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = a;
      req_wdata    = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      k = 1;
      while (!resp_valid && k < 10) begin
         @(posedge clk); #1;
         k++;
      end
      chk({tag, ".lat"}, k, exp_lat);
      chk({tag, ".err"}, {31'h0, resp_err}, {31'h0, exp_err});
      chk({tag, ".rdata"}, resp_rdata, exp_rd);
      @(posedge clk); #1;
      chk({tag, ".pulse"}, {31'h0, resp_valid}, 32'd0);
      chk({tag, ".hold"}, resp_rdata, exp_rd);
      chk({tag, ".we_cnt"}, we_cnt, exp_we);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[0] = 32'h8899AABB;
      mem[1] = 32'h11223344;
      mem[2] = 32'hCAFEF00D;
      we_cnt       = 0;
      rst_n        = 1'b0;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst.ready", {31'h0, req_ready}, 32'd1);
      chk("rst.valid", {31'h0, resp_valid}, 32'd0);
      chk("rst.err", {31'h0, resp_err}, 32'd0);
      chk("rst.rdata", resp_rdata, 32'h0);
      chk("rst.mem_we", {31'h0, mem_we}, 32'd0);
      chk("rst.mem_addr", mem_addr, 32'h0);
      rst_n = 1'b1;

      run("lb_s_1", 1'b0, 2'b00, 1'b0, 32'h1, 32'h0, 2, 1'b0,
          32'hFFFFFFAA, 0);
      run("lh_u_2", 1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 2, 1'b0,
          32'h00008899, 0);
      run("lb_u_3", 1'b0, 2'b00, 1'b1, 32'h3, 32'h0, 2, 1'b0,
          32'h00000088, 0);
      run("lh_s_0", 1'b0, 2'b01, 1'b0, 32'h0, 32'h0, 2, 1'b0,
          32'hFFFFAABB, 0);
      run("lw_4", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 2, 1'b0,
          32'h11223344, 0);

      run("sb_2", 1'b1, 2'b00, 1'b0, 32'h2, 32'h0000005A, 3, 1'b0,
          32'h0, 1);
      chk("sb_2.mem", mem[0], 32'h885AAABB);
      run("sh_6", 1'b1, 2'b01, 1'b0, 32'h6, 32'hFFFF1234, 3, 1'b0,
          32'h0, 1);
      chk("sh_6.mem", mem[1], 32'h12343344);
      run("sw_c", 1'b1, 2'b10, 1'b0, 32'hC, 32'hDEADBEEF, 2, 1'b0,
          32'h0, 1);
      chk("sw_c.mem", mem[3], 32'hDEADBEEF);

`ifdef LSU_MISALIGN_TRAP_EN
      run("lw_6", 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 1, 1'b1, 32'h0, 0);
`else
      run("lw_6", 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 2, 1'b0,
          32'h12343344, 0);
`endif

      run("size11", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1, 1'b1, 32'h0, 0);
      run("oob_sw", 1'b1, 2'b10, 1'b0, 32'h00061A84, 32'h12345678, 1,
          1'b1, 32'h0, 0);
      run("lw_0b", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 2, 1'b0,
          32'h885AAABB, 0);

      // Reset asserted while the word store to 0x8 sits in WRITE.
      @(posedge clk); #1;
      we_cnt    = 0;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'b10;
      req_addr  = 32'h8;
      req_wdata = 32'h0BADF00D;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rstw.in_write", {31'h0, mem_we}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rstw.mem", mem[2], 32'hCAFEF00D);
      chk("rstw.we_cnt", we_cnt, 0);
      chk("rstw.ready", {31'h0, req_ready}, 32'd1);
      chk("rstw.valid", {31'h0, resp_valid}, 32'd0);
      @(posedge clk); #1;
      chk("rstw.no_resp", {31'h0, resp_valid}, 32'd0);
      chk("rstw.mem2", mem[2], 32'hCAFEF00D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
